// File: rtl/pwm_capture.sv
`default_nettype none
// ============================================================================
// Module      : pwm_capture
// Description : Bus-mapped PWM measurement peripheral. Synchronizes an
//               external PWM input, measures the high time and period of
//               each complete cycle in clk cycles and exposes the results
//               through a select/write/read-data slave bus.
//
// Ports       : clk       - system clock, rising edge
//               rst       - synchronous active-high reset
//               bSel      - block select
//               bWrite    - write strobe (write when bSel & bWrite)
//               bAddr     - register index (0 CTRL, 1 STATUS, 2 HIGH, 3 PERIOD)
//               bWData    - write data
//               bRData    - read data, combinational from bAddr
//               pwmInput  - asynchronous PWM input
//               capValid  - mirror of STATUS.VALID (sticky)
//
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_capture #(
    parameter int CNT_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bSel,
    input  logic        bWrite,
    input  logic [1:0]  bAddr,
    input  logic [31:0] bWData,
    output logic [31:0] bRData,
    input  logic        pwmInput,
    output logic        capValid
);

    localparam logic [1:0] c_OFF  = 2'd0;
    localparam logic [1:0] c_ARM  = 2'd1;
    localparam logic [1:0] c_MEAS = 2'd2;

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    localparam logic [1:0] c_ADDR_CTRL   = 2'd0;
    localparam logic [1:0] c_ADDR_STATUS = 2'd1;
    localparam logic [1:0] c_ADDR_HIGH   = 2'd2;
    localparam logic [1:0] c_ADDR_PERIOD = 2'd3;

    // Input path
    logic             r_sync1;
    logic             r_lvl;
    logic             r_lvl_d;
    logic             w_rise;

    // Registers
    logic             r_en;
    logic             r_valid;
    logic             r_ovf;
    logic [CNT_W-1:0] r_high;
    logic [CNT_W-1:0] r_period;

    // Measurement engine
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_per_cnt;
    logic [CNT_W-1:0] r_hi_cnt;

    logic             w_wr;
    logic             w_wr_ctrl;
    logic             w_clr_valid;
    logic             w_clr_ovf;
    logic             w_in_meas;
    logic             w_per_full;
    logic             w_latch;
    logic             w_ovf_evt;
    logic             w_unused;

    // ------------------------------------------------------------------
    // Two-flop synchronizer plus one delay flop for rising-edge detect
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_lvl   <= 1'b0;
            r_lvl_d <= 1'b0;
        end else begin
            r_sync1 <= pwmInput;
            r_lvl   <= r_sync1;
            r_lvl_d <= r_lvl;
        end
    end

    assign w_rise = r_lvl & ~r_lvl_d;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    assign w_wr        = bSel & bWrite;
    assign w_wr_ctrl   = w_wr && (bAddr == c_ADDR_CTRL);
    assign w_clr_valid = w_wr && (bAddr == c_ADDR_STATUS) && bWData[0];
    assign w_clr_ovf   = w_wr && (bAddr == c_ADDR_STATUS) && bWData[1];

    // Only bits 1:0 of the write data are ever used.
    assign w_unused = ^bWData[31:2];

    // ------------------------------------------------------------------
    // Measurement events. A full period counter takes priority over a
    // coincident edge, so a period of all-ones cycles reports overflow
    // rather than a truncated result. Nothing happens while disabled.
    // ------------------------------------------------------------------
    assign w_in_meas  = r_en && (r_state == c_MEAS);
    assign w_per_full = (r_per_cnt == c_CNT_MAX);
    assign w_ovf_evt  = w_in_meas && w_per_full;
    assign w_latch    = w_in_meas && !w_per_full && w_rise;

    // ------------------------------------------------------------------
    // FSM and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_OFF;
            r_per_cnt <= '0;
            r_hi_cnt  <= '0;
        end else if (!r_en) begin
            r_state   <= c_OFF;
            r_per_cnt <= '0;
            r_hi_cnt  <= '0;
        end else begin
            case (r_state)
                c_OFF: begin
                    r_state   <= c_ARM;
                    r_per_cnt <= '0;
                    r_hi_cnt  <= '0;
                end
                c_ARM: begin
                    // First edge only starts a measurement.
                    if (w_rise) begin
                        r_per_cnt <= c_CNT_ONE;
                        r_hi_cnt  <= c_CNT_ONE;
                        r_state   <= c_MEAS;
                    end
                end
                c_MEAS: begin
                    if (w_per_full) begin
                        r_state <= c_ARM;
                    end else if (w_rise) begin
                        // The rise cycle is the first high cycle of the
                        // next period.
                        r_per_cnt <= c_CNT_ONE;
                        r_hi_cnt  <= c_CNT_ONE;
                    end else begin
                        r_per_cnt <= r_per_cnt + c_CNT_ONE;
                        if (r_lvl && (r_hi_cnt != c_CNT_MAX)) begin
                            r_hi_cnt <= r_hi_cnt + c_CNT_ONE;
                        end
                    end
                end
                default: begin
                    r_state   <= c_OFF;
                    r_per_cnt <= '0;
                    r_hi_cnt  <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Control, status and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_en     <= 1'b0;
            r_valid  <= 1'b0;
            r_ovf    <= 1'b0;
            r_high   <= '0;
            r_period <= '0;
        end else begin
            if (w_wr_ctrl) begin
                r_en <= bWData[0];
            end
            // Set wins over a same-cycle write-one-to-clear.
            r_valid <= w_latch   | (r_valid & ~w_clr_valid);
            r_ovf   <= w_ovf_evt | (r_ovf   & ~w_clr_ovf);
            if (w_latch) begin
                r_high   <= r_hi_cnt;
                r_period <= r_per_cnt;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    always_comb begin
        bRData = '0;
        case (bAddr)
            c_ADDR_CTRL:   bRData[0]         = r_en;
            c_ADDR_STATUS: bRData[2:0]       = {r_lvl, r_ovf, r_valid};
            c_ADDR_HIGH:   bRData[CNT_W-1:0] = r_high;
            c_ADDR_PERIOD: bRData[CNT_W-1:0] = r_period;
            default:       bRData            = '0;
        endcase
    end

    assign capValid = r_valid;

endmodule
`default_nettype wire

// File: doc/pwm_capture.md
# pwm_capture

Bus-mapped PWM measurement peripheral: the receive-side counterpart of the team's PWM generator. It samples an external PWM waveform, measures the high time and period of each complete cycle in `clk` cycles, and exposes the results through the same simple select/write/read-data slave bus. Typical use is loop-back verification of a PWM output, or decoding an external sensor or servo PWM.

## Interface
- `CNT_W`, default 16: width of the high-time and period counters (valid range 8..31).
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `bSel`  in  1  block select.
- `bWrite`  in  1  write strobe; a write occurs when `bSel & bWrite`.
- `bAddr`  in  2  register index.
- `bWData`  in  32  write data.
- `bRData`  out  32  read data; combinational from `bAddr`, independent of `bSel`.
- `pwmInput`  in  1  asynchronous PWM input.
- `capValid`  out  1  mirror of STATUS.VALID (sticky; usable as an interrupt).

## Operation
- **Input path:** 2-flop synchronizer, then a third flop for edge detection.
  - `lvl` is the synchronized level.
  - `rise = lvl & ~lvl_d`.
- **Register map** (unused read bits are 0):
  - 0 CTRL, RW: bit0 EN.
  - 1 STATUS, R / W1C: bit0 VALID, bit1 OVF, bit2 LVL (live `lvl`, read-only).
  - 2 HIGH, RO: last latched high time, zero-extended.
  - 3 PERIOD, RO: last latched period, zero-extended.
- **FSM states:** OFF, ARM, MEAS.
  - OFF: counters are held at 0. EN=1 moves to ARM.
  - ARM: wait for `rise`. On `rise`: `perCnt<=1`, `hiCnt<=1`, go to MEAS. Nothing is latched.
  - MEAS: every cycle `perCnt++`; `hiCnt++` when `lvl=1` and not `rise`.
    - On `rise`: `HIGH<=hiCnt`, `PERIOD<=perCnt`, VALID<=1, restart with `perCnt<=1`, `hiCnt<=1`, stay in MEAS.
    - If `perCnt` equals all-ones without a `rise`: OVF<=1, go to ARM. HIGH and PERIOD keep their old values.
  - Any state: EN=0 returns to OFF next cycle. HIGH, PERIOD and STATUS are retained.
- **Result:** for a stable input with H high cycles and L low cycles, HIGH=H and PERIOD=H+L.
- `hiCnt` saturates at all-ones; it can never exceed `perCnt`.
- **Status bit priority:** a W1C write and a set event in the same cycle leave the bit set (set wins). Writing 0 to a STATUS bit has no effect.
- **Latch vs. read:** a HIGH/PERIOD update and a read in the same cycle return the old value; the new value appears the next cycle.
- **Reserved bits:** writes to addresses 2 and 3 are ignored. CTRL bits [31:1] are ignored.

## Timing
- **Reset values:**
  - `bRData` reads 0 for CTRL, HIGH and PERIOD. For STATUS it reads 0 except bit2, which reflects the synchronized input once the synchronizer is loaded.
  - `capValid` = 0.
  - FSM = OFF.
  - Synchronizer flops = 0.
- **Reset** mid-measurement aborts immediately. No latch occurs.
- **Input latency:** a `pwmInput` transition produces `rise` 2–3 cycles later, depending on arrival phase relative to `clk`.
- **Result latency:** HIGH, PERIOD and VALID update on the clock edge at which `rise` is asserted. They are readable, and `capValid` is high, one cycle after that edge.
- **Register writes** take effect at the clock edge. An EN write is acted on by the FSM starting the next cycle.
- **Minimum measurable period:** 2 cycles (H≥1, L≥1). Shorter pulses may be missed by the synchronizer; this is undefined but must not hang the FSM.
- **Maximum measurable period:** 2^CNT_W − 2 cycles. Periods of 2^CNT_W − 1 or longer set OVF.

## Test plan
- **Reset check:** assert `rst` 3 cycles with `pwmInput` toggling → all four registers read 0 (LVL excepted), `capValid`=0, FSM in OFF.
- **Basic capture:** EN=1; input H=30, L=70 repeated → after the second rising edge HIGH=30, PERIOD=100, VALID=1. Values are stable across subsequent cycles.
- **Duty change:** switch to H=1, L=1, then H=99, L=1 → HIGH/PERIOD read 1/2, then 99/100, each after the first full new cycle.
- **Overflow:** CNT_W=8; hold input low after one rising edge → OVF=1 exactly 255 cycles after the `rise`, FSM returns to ARM, HIGH/PERIOD unchanged. The next good cycle sets VALID.
- **W1C clash:** write STATUS=0x3 in the same cycle a `rise` latches → VALID stays 1 and OVF clears. A second write of 0x1 with no edge clears VALID and drops `capValid`.
- **Disable/reset mid-measure:** EN=0 mid-high-phase → OFF, old results retained. Re-enable → the first edge only arms, the second latches. Separately, `rst` mid-measure → all registers cleared.
